hwpe_ctrl_job_dispatcher: RTL and testbench
===========================================

# hwpe_ctrl_job_dispatcher

Sequencer that shares one HWPE engine between up to `N_CORES` offloading cores through a ring of `N_CONTEXT` job contexts. It sits between the slave register-file front end and the engine datapath. It owns acquire/trigger bookkeeping and the pointer and running context indices, issues `start_o` to the engine, and returns a per-core completion event when `engine_done_i` arrives.

## Interface
Parameters:
- `N_CONTEXT`, 2: number of job contexts; power of two, at least 2.
- `N_CORES`, 16: number of offloading cores.
- `CTX_W`, `$clog2(N_CONTEXT)`: context index width.
- `ID_W`, `$clog2(N_CORES)`: core ID width.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: reset. Synchronous, active-high.
- `acquire_req_i` in 1: a core reads the acquire register (test-and-set).
- `acquire_id_i` in `ID_W`: ID of the requesting core.
- `acquire_valid_o` out 1: acquire response valid. One-cycle pulse.
- `acquire_granted_o` out 1: the acquire was granted. Meaningful only with `acquire_valid_o`.
- `acquire_ctx_o` out `CTX_W`: context assigned by the grant.
- `trigger_i` in 1: the holder of the lock commits its job.
- `pointer_ctx_o` out `CTX_W`: context that the next acquire will get.
- `running_ctx_o` out `CTX_W`: context currently or next executed.
- `start_o` out 1: start pulse to the engine.
- `engine_done_i` in 1: completion pulse from the engine.
- `busy_o` out 1: the engine FSM is not IDLE.
- `evt_o` out `N_CORES`: completion event, one-hot to the owner core. One-cycle pulse.
- `nb_occupied_o` out `$clog2(N_CONTEXT+1)`: number of non-free contexts.

## Operation
- **Per-context state:** FREE, ACQUIRED, QUEUED or RUNNING, plus a stored owner ID.
- **Registers:**
  - `ptr_q`: write pointer.
  - `run_q`: read pointer.
  - `cnt_q`: occupied count.
  - `lock_q`: an ACQUIRED context exists.
- **Acquire:** granted iff `!lock_q && cnt_q < N_CONTEXT`. On grant:
  - context `ptr_q` becomes ACQUIRED;
  - its owner is set to `acquire_id_i`;
  - `lock_q` is set and `cnt_q` increments.
  - On denial no state changes.
- **Trigger:** when `lock_q` is set, context `ptr_q` becomes QUEUED, `ptr_q` advances by 1 mod `N_CONTEXT`, and `lock_q` clears. `trigger_i` without `lock_q` is ignored.
- **Engine FSM:**
  - IDLE: goes to START if context `run_q` is QUEUED.
  - START: `start_o`=1 and the context becomes RUNNING; goes to RUN.
  - RUN: on `engine_done_i` goes to DONE.
  - DONE: `evt_o[owner]`=1, the context becomes FREE, `run_q` advances mod `N_CONTEXT`, `cnt_q` decrements; goes to START if the new `run_q` context is QUEUED, else IDLE.
- `engine_done_i` outside RUN is ignored.
- Pointer wrap: `N_CONTEXT-1` wraps to 0 for both pointers.
- **Same-cycle events:**
  - Grant and DONE-free in the same cycle: `cnt_q` is unchanged net. The acquire decision uses the pre-cycle `cnt_q`, so a full ring denies even while DONE frees a slot.
  - Acquire and trigger in the same cycle: the acquire sees the pre-cycle `lock_q`=1 and is denied. The trigger is applied.
- `cnt_q` never exceeds `N_CONTEXT` and never underflows. The implementation includes assertions for both.

## Timing
- **Reset values:**
  - All outputs 0.
  - All contexts FREE, owners 0.
  - `ptr_q`, `run_q`, `cnt_q` and `lock_q` 0.
  - FSM in IDLE.
- Reset has priority over every input in the same cycle and aborts a running job with no `evt_o`. The engine is reset by the same `rst_i`.
- **Acquire:** request at cycle t gives `acquire_valid_o`, `acquire_granted_o` and `acquire_ctx_o` registered at t+1. `pointer_ctx_o` and `nb_occupied_o` update at t+1.
- **Trigger:** at t the context is QUEUED at t+1. With the FSM in IDLE, `start_o` is high at t+2 and `busy_o` is high from t+2.
- **Done:** `engine_done_i` in RUN at t gives `evt_o` at t+1 (DONE state). The freed slot is visible at t+2.
  - Back-to-back case: if the next context is QUEUED, `start_o` is at t+2.
  - Otherwise `busy_o` falls at t+2.
- `start_o` and `evt_o` are exactly one cycle wide.
- `evt_o` is never asserted together with `start_o`.

## Test plan
- **Single job:** reset, then acquire from id 3 at t=0, trigger at t=2, done at t=10.
  - Grant with ctx 0 at t=1.
  - `start_o` at t=4.
  - `evt_o`=16'h0008 at t=11.
  - `busy_o` low and `nb_occupied_o`=0 at t=12.
- **Lock:** acquire (id 1) granted, then a second acquire (id 2) before trigger -> denied, `cnt` stays 1. After the trigger, id 2's acquire is granted with ctx 1.
- **Full and wrap:**
  - Fill both contexts (ids 0, 5). A third acquire -> denied.
  - After the first done: acquire granted with ctx 0 (wrap).
  - `evt_o` order: bit 0, then bit 5.
  - Second `start_o` exactly 2 cycles after the first done.
- **Simultaneous events:**
  - Full ring: acquire in the same cycle as DONE -> denied. Retry next cycle -> granted.
  - Acquire in the same cycle as trigger -> denied, trigger applied.
- **Spurious inputs:**
  - `trigger_i` without lock -> no queue change, no `start_o`.
  - `engine_done_i` in IDLE -> no `evt_o`.
- **Reset mid-run:** `rst_i` during RUN -> next cycle all outputs 0, FSM IDLE, no `evt_o`. A fresh acquire is granted ctx 0.

Source files
------------

// File: rtl/hwpe_ctrl_job_dispatcher.sv
// rtl/hwpe_ctrl_job_dispatcher.sv - job-context ring and engine sequencer shared by offloading cores
module hwpe_ctrl_job_dispatcher #(
    parameter int N_CONTEXT = 2,
    parameter int N_CORES   = 16,
    parameter int CTX_W     = $clog2(N_CONTEXT),
    parameter int ID_W      = $clog2(N_CORES)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           acquire_req_i,
    input  logic [ID_W-1:0]                acquire_id_i,
    output logic                           acquire_valid_o,
    output logic                           acquire_granted_o,
    output logic [CTX_W-1:0]               acquire_ctx_o,
    input  logic                           trigger_i,
    output logic [CTX_W-1:0]               pointer_ctx_o,
    output logic [CTX_W-1:0]               running_ctx_o,
    output logic                           start_o,
    input  logic                           engine_done_i,
    output logic                           busy_o,
    output logic [N_CORES-1:0]             evt_o,
    output logic [$clog2(N_CONTEXT+1)-1:0] nb_occupied_o
);

    localparam int CNT_W = $clog2(N_CONTEXT + 1);
    localparam logic [CNT_W-1:0]   CNT_FULL = CNT_W'(N_CONTEXT);
    localparam logic [N_CORES-1:0] EVT_ONE  = N_CORES'(1);

    localparam logic [1:0] CTX_FREE   = 2'd0;
    localparam logic [1:0] CTX_ACQ    = 2'd1;
    localparam logic [1:0] CTX_QUEUED = 2'd2;
    localparam logic [1:0] CTX_RUN    = 2'd3;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       ctx_state_q [N_CONTEXT];
    logic [1:0]       ctx_state_d [N_CONTEXT];
    logic [ID_W-1:0]  owner_q     [N_CONTEXT];
    logic [ID_W-1:0]  owner_d     [N_CONTEXT];
    logic [CTX_W-1:0] ptr_q, ptr_d, run_q, run_d, run_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lock_q, lock_d;
    logic [1:0]       fsm_q, fsm_d;
    logic             acq_valid_q, acq_valid_d;
    logic             acq_granted_q, acq_granted_d;
    logic [CTX_W-1:0] acq_ctx_q, acq_ctx_d;
    logic             grant, trig_ok, done_free;

    always_comb begin
        // Decisions use pre-cycle lock/count only, so a slot freed by DONE this cycle is not reusable yet
        grant     = acquire_req_i && !lock_q && (cnt_q < CNT_FULL);
        trig_ok   = trigger_i && lock_q;
        done_free = (fsm_q == S_DONE);
        run_nxt   = run_q + CTX_W'(1);

        ctx_state_d   = ctx_state_q;
        owner_d       = owner_q;
        ptr_d         = ptr_q;
        run_d         = run_q;
        lock_d        = lock_q;
        fsm_d         = fsm_q;
        acq_valid_d   = acquire_req_i;
        acq_granted_d = grant;
        acq_ctx_d     = grant ? ptr_q : '0;

        if (grant) begin
            ctx_state_d[ptr_q] = CTX_ACQ;
            owner_d[ptr_q]     = acquire_id_i;
            lock_d             = 1'b1;
        end
        if (trig_ok) begin
            ctx_state_d[ptr_q] = CTX_QUEUED;
            ptr_d              = ptr_q + CTX_W'(1);
            lock_d             = 1'b0;
        end

        case (fsm_q)
            S_IDLE: begin
                if (ctx_state_q[run_q] == CTX_QUEUED) fsm_d = S_START;
            end
            S_START: begin
                ctx_state_d[run_q] = CTX_RUN;
                fsm_d              = S_RUN;
            end
            S_RUN: begin
                if (engine_done_i) fsm_d = S_DONE;
            end
            default: begin
                ctx_state_d[run_q] = CTX_FREE;
                run_d              = run_nxt;
                fsm_d              = (ctx_state_q[run_nxt] == CTX_QUEUED) ? S_START : S_IDLE;
            end
        endcase

        case ({grant, done_free})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < N_CONTEXT; i++) begin
                ctx_state_q[i] <= CTX_FREE;
                owner_q[i]     <= '0;
            end
            ptr_q         <= '0;
            run_q         <= '0;
            cnt_q         <= '0;
            lock_q        <= 1'b0;
            fsm_q         <= S_IDLE;
            acq_valid_q   <= 1'b0;
            acq_granted_q <= 1'b0;
            acq_ctx_q     <= '0;
        end else begin
            ctx_state_q   <= ctx_state_d;
            owner_q       <= owner_d;
            ptr_q         <= ptr_d;
            run_q         <= run_d;
            cnt_q         <= cnt_d;
            lock_q        <= lock_d;
            fsm_q         <= fsm_d;
            acq_valid_q   <= acq_valid_d;
            acq_granted_q <= acq_granted_d;
            acq_ctx_q     <= acq_ctx_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (cnt_q <= CNT_FULL);
            assert (!(done_free && cnt_q == '0));
        end
    end

    assign acquire_valid_o   = acq_valid_q;
    assign acquire_granted_o = acq_granted_q;
    assign acquire_ctx_o     = acq_ctx_q;
    assign pointer_ctx_o     = ptr_q;
    assign running_ctx_o     = run_q;
    assign start_o           = (fsm_q == S_START);
    assign busy_o            = (fsm_q != S_IDLE);
    assign evt_o             = done_free ? (EVT_ONE << owner_q[run_q]) : '0;
    assign nb_occupied_o     = cnt_q;

endmodule

// File: tb/tb_hwpe_ctrl_job_dispatcher.sv
// tb/tb_hwpe_ctrl_job_dispatcher.sv - directed and randomized checks of the job dispatcher
module tb_hwpe_ctrl_job_dispatcher;

    localparam int NCTX = 2;
    localparam int NCOR = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [3:0]  id;
    logic        trig;
    logic        done;
    logic        acq_valid, acq_granted;
    logic [0:0]  acq_ctx, ptr_ctx, run_ctx;
    logic        start, busy;
    logic [15:0] evt;
    logic [1:0]  nb;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        int owner;
        int trig;
        int start;
        int evt;
    } job_t;

    job_t jq[$];

    hwpe_ctrl_job_dispatcher #(.N_CONTEXT(NCTX), .N_CORES(NCOR)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .acquire_req_i    (req),
        .acquire_id_i     (id),
        .acquire_valid_o  (acq_valid),
        .acquire_granted_o(acq_granted),
        .acquire_ctx_o    (acq_ctx),
        .trigger_i        (trig),
        .pointer_ctx_o    (ptr_ctx),
        .running_ctx_o    (run_ctx),
        .start_o          (start),
        .engine_done_i    (done),
        .busy_o           (busy),
        .evt_o            (evt),
        .nb_occupied_o    (nb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        req  = 1'b0;
        trig = 1'b0;
        done = 1'b0;
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, acq_valid, 0);
        chk({tag, "_grant"}, acq_granted, 0);
        chk({tag, "_start"}, start, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_evt"}, evt, 0);
        chk({tag, "_nb"}, nb, 0);
        chk({tag, "_ptr"}, ptr_ctx, 0);
        chk({tag, "_run"}, run_ctx, 0);
    endtask

    initial begin
        int  m_cnt, m_ptr, m_run, m_holder, last_evt, p_ctx;
        bit  m_lock, p_valid, p_grant, g, tr, evt_now;
        int  exp_evt;

        rst = 1'b1; req = 1'b0; id = '0; trig = 1'b0; done = 1'b0;

        // Single job
        do_reset();
        chk_all_zero("reset");
        req = 1'b1; id = 4'd3; step();
        chk("single_valid", acq_valid, 1);
        chk("single_grant", acq_granted, 1);
        chk("single_ctx", acq_ctx, 0);
        chk("single_nb1", nb, 1);
        wait_to(2); trig = 1'b1; step();
        chk("single_nostart3", start, 0);
        step();
        chk("single_start4", start, 1);
        chk("single_busy4", busy, 1);
        step();
        chk("single_start_width", start, 0);
        wait_to(10); done = 1'b1; step();
        chk("single_evt", evt, 16'h0008);
        step();
        chk("single_evt_width", evt, 0);
        chk("single_busy12", busy, 0);
        chk("single_nb12", nb, 0);

        // Lock
        do_reset();
        req = 1'b1; id = 4'd1; step();
        chk("lock_grant1", acq_granted, 1);
        req = 1'b1; id = 4'd2; step();
        chk("lock_valid2", acq_valid, 1);
        chk("lock_denied2", acq_granted, 0);
        chk("lock_nb", nb, 1);
        trig = 1'b1; step();
        req = 1'b1; id = 4'd2; step();
        chk("lock_grant3", acq_granted, 1);
        chk("lock_ctx3", acq_ctx, 1);

        // Full ring, wrap, same-cycle DONE/acquire
        do_reset();
        req = 1'b1; id = 4'd0; step();
        trig = 1'b1; step();
        req = 1'b1; id = 4'd5; step();
        chk("full_grant_b", acq_granted, 1);
        chk("full_nb2", nb, 2);
        trig = 1'b1; step();
        req = 1'b1; id = 4'd9; step();
        chk("full_denied", acq_granted, 0);
        wait_to(6); done = 1'b1; step();
        chk("full_evt0", evt, 16'h0001);
        chk("full_evt0_nostart", start, 0);
        req = 1'b1; id = 4'd7; step();
        chk("done_same_denied", acq_granted, 0);
        chk("b2b_start", start, 1);
        chk("b2b_evt_clear", evt, 0);
        chk("full_nb_after_done", nb, 1);
        chk("full_run_ctx", run_ctx, 1);
        req = 1'b1; id = 4'd7; step();
        chk("retry_grant", acq_granted, 1);
        chk("wrap_ctx", acq_ctx, 0);
        trig = 1'b1; step();
        wait_to(11); done = 1'b1; step();
        chk("full_evt5", evt, 16'h0020);
        step();
        chk("full_start3", start, 1);
        wait_to(15); done = 1'b1; step();
        chk("full_evt7", evt, 16'h0080);
        step();
        chk("full_idle_busy", busy, 0);
        chk("full_idle_nb", nb, 0);
        chk("full_idle_ptr", ptr_ctx, 1);
        chk("full_idle_run", run_ctx, 1);

        // Acquire together with trigger
        do_reset();
        req = 1'b1; id = 4'd2; step();
        req = 1'b1; id = 4'd4; trig = 1'b1; step();
        chk("acqtrig_valid", acq_valid, 1);
        chk("acqtrig_denied", acq_granted, 0);
        chk("acqtrig_ptr", ptr_ctx, 1);
        chk("acqtrig_nb", nb, 1);
        step();
        chk("acqtrig_start", start, 1);

        // Spurious trigger and done
        do_reset();
        trig = 1'b1; done = 1'b1; step();
        chk("spur_ptr", ptr_ctx, 0);
        chk("spur_evt1", evt, 0);
        step();
        chk("spur_start", start, 0);
        chk("spur_busy", busy, 0);
        chk("spur_evt2", evt, 0);

        // Reset mid-run
        do_reset();
        req = 1'b1; id = 4'd6; step();
        trig = 1'b1; step();
        wait_to(4);
        chk("midrun_busy", busy, 1);
        step();
        rst = 1'b1; done = 1'b1; step();
        rst = 1'b0;
        chk_all_zero("midrun");
        req = 1'b1; id = 4'd1; step();
        chk("midrun_regrant", acq_granted, 1);
        chk("midrun_ctx", acq_ctx, 0);

        // Randomized run against a job-level timing model
        do_reset();
        jq.delete();
        m_cnt = 0; m_ptr = 0; m_run = 0; m_holder = 0; last_evt = -100;
        m_lock = 0; p_valid = 0; p_grant = 0; p_ctx = 0;
        for (int k = 0; k < 3000; k++) begin
            // A job starts two cycles after its trigger, but never before the previous event has retired
            if (jq.size() > 0 && jq[0].start < 0)
                jq[0].start = (jq[0].trig + 2 > last_evt + 1) ? jq[0].trig + 2 : last_evt + 1;
            exp_evt = (jq.size() > 0 && jq[0].evt == k) ? (1 << jq[0].owner) : 0;
            chk("rnd_start", start, (jq.size() > 0 && jq[0].start == k) ? 1 : 0);
            chk("rnd_busy", busy, (jq.size() > 0 && jq[0].start >= 0 && jq[0].start <= k) ? 1 : 0);
            chk("rnd_evt", evt, exp_evt);
            chk("rnd_nb", nb, m_cnt);
            chk("rnd_ptr", ptr_ctx, m_ptr % NCTX);
            chk("rnd_run", run_ctx, m_run % NCTX);
            chk("rnd_valid", acq_valid, p_valid);
            if (p_valid) chk("rnd_grant", acq_granted, p_grant);
            if (p_grant) chk("rnd_ctx", acq_ctx, p_ctx);

            req  = ($urandom % 3) == 0;
            id   = 4'($urandom % NCOR);
            trig = ($urandom % 4) == 0;
            done = ($urandom % 3) == 0;

            g       = req && !m_lock && (m_cnt < NCTX);
            tr      = trig && m_lock;
            evt_now = (jq.size() > 0 && jq[0].evt == k);
            p_valid = req;
            p_grant = g;
            p_ctx   = m_ptr % NCTX;
            if (done && jq.size() > 0 && jq[0].start >= 0 && k >= jq[0].start + 1 && jq[0].evt < 0)
                jq[0].evt = k + 1;
            if (tr) begin
                jq.push_back('{m_holder, k, -1, -1});
                m_ptr++;
                m_lock = 0;
            end
            if (g) begin
                m_lock   = 1;
                m_holder = int'(id);
                m_cnt++;
            end
            if (evt_now) begin
                m_cnt--;
                m_run++;
                last_evt = k;
                void'(jq.pop_front());
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
